// File: rtl/piso_pkg.sv
// Shared types and defaults for the parallel-in/serial-out transmitter.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/piso_tx_if.sv
// Parallel word input handshake plus serial output stream of piso_tx.
interface piso_tx_if
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             so;
  logic             so_valid;
  logic             so_last;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, so, so_valid, so_last, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, so, so_valid, so_last, busy
  );

endinterface

// File: rtl/piso_bitcnt.sv
// Loadable down-counter with zero flag; it holds at zero instead of wrapping.
module piso_bitcnt #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/piso_tx.sv
// Serializes WIDTH-bit words one bit per cycle, MSB- or LSB-first, with back-to-back accept.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b0
) (
  input logic       clk,
  input logic       rst,
  piso_tx_if.slave  bus
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q;
  logic             shifting;
  logic             last_bit;
  logic             ready;
  logic             accept;
  logic             cnt_zero;
  logic             so_bit;

  always_comb begin
    shifting = (state_q == SHIFT);
    last_bit = shifting && cnt_zero;
    ready    = !shifting || last_bit;
    accept   = bus.din_valid && ready;
    so_bit   = 1'b0;
    if (shifting) begin
      so_bit = LSB_FIRST ? sr_q[0] : sr_q[WIDTH-1];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (cnt_zero && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Accept wins over shifting so a word captured on the last-bit cycle starts intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else if (accept) begin
      sr_q <= bus.din;
    end else if (shifting) begin
      sr_q <= LSB_FIRST ? (sr_q >> 1) : (sr_q << 1);
    end
  end

  piso_bitcnt #(
    .CW (CW)
  ) u_bitcnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (LAST_IDX),
    .dec      (shifting),
    .zero     (cnt_zero)
  );

  assign bus.din_ready = ready;
  assign bus.so        = so_bit;
  assign bus.so_valid  = shifting;
  assign bus.so_last   = last_bit;
  assign bus.busy      = shifting;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: three instances (4-bit MSB-first, 4-bit LSB-first, 8-bit MSB-first) against a word-queue model.
module tb_piso_tx;

  logic clk;
  logic rst;
  logic chk_on;
  int   total;
  int   bad;

  piso_tx_if #(.WIDTH(4)) if0 ();
  piso_tx_if #(.WIDTH(4)) if1 ();
  piso_tx_if #(.WIDTH(8)) if2 ();

  piso_tx #(.WIDTH(4), .LSB_FIRST(1'b0)) u0 (.clk(clk), .rst(rst), .bus(if0));
  piso_tx #(.WIDTH(4), .LSB_FIRST(1'b1)) u1 (.clk(clk), .rst(rst), .bus(if1));
  piso_tx #(.WIDTH(8), .LSB_FIRST(1'b0)) u2 (.clk(clk), .rst(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance views so a single compare loop covers all three.
  logic        dv  [3];
  logic [31:0] din_a [3];
  logic        so_a [3], vld_a [3], last_a [3], busy_a [3], rdy_a [3];
  int unsigned wid  [3] = '{4, 4, 8};
  bit          lsbf [3] = '{1'b0, 1'b1, 1'b0};

  assign dv[0] = if0.din_valid;  assign din_a[0] = 32'(if0.din);
  assign dv[1] = if1.din_valid;  assign din_a[1] = 32'(if1.din);
  assign dv[2] = if2.din_valid;  assign din_a[2] = 32'(if2.din);
  assign so_a[0] = if0.so; assign vld_a[0] = if0.so_valid; assign last_a[0] = if0.so_last;
  assign busy_a[0] = if0.busy; assign rdy_a[0] = if0.din_ready;
  assign so_a[1] = if1.so; assign vld_a[1] = if1.so_valid; assign last_a[1] = if1.so_last;
  assign busy_a[1] = if1.busy; assign rdy_a[1] = if1.din_ready;
  assign so_a[2] = if2.so; assign vld_a[2] = if2.so_valid; assign last_a[2] = if2.so_last;
  assign busy_a[2] = if2.busy; assign rdy_a[2] = if2.din_ready;

  task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", nm, d, $time, act, exp);
    end
  endtask

  function automatic logic bit_of(input logic [31:0] w, input int unsigned width,
                                  input bit lsb_first, input int unsigned i);
    return lsb_first ? w[i] : w[width-1-i];
  endfunction

  // Model: queue of accepted words, current bit position, and a serial capture register.
  logic [31:0] wbuf [3][2];
  int unsigned cnt  [3];
  int unsigned pos  [3];
  logic [31:0] cap  [3];
  logic        m_has, m_last, m_so, m_ready;
  logic [31:0] m_mask;

  initial begin
    for (int d = 0; d < 3; d++) begin
      cnt[d] = 0; pos[d] = 0; cap[d] = '0;
      wbuf[d][0] = '0; wbuf[d][1] = '0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 3; d++) begin
        m_has   = (cnt[d] != 0);
        m_last  = m_has && (pos[d] == wid[d] - 1);
        m_so    = m_has ? bit_of(wbuf[d][0], wid[d], lsbf[d], pos[d]) : 1'b0;
        m_ready = !m_has || m_last;
        m_mask  = 32'((64'd1 << wid[d]) - 1);
        check("so_valid",  d, 32'(vld_a[d]),  32'(m_has));
        check("so",        d, 32'(so_a[d]),   32'(m_so));
        check("so_last",   d, 32'(last_a[d]), 32'(m_last));
        check("busy",      d, 32'(busy_a[d]), 32'(m_has));
        check("din_ready", d, 32'(rdy_a[d]),  32'(m_ready));
        if (m_has) begin
          if (lsbf[d]) cap[d] = (cap[d] >> 1) | (32'(so_a[d]) << (wid[d] - 1));
          else         cap[d] = (cap[d] << 1) | 32'(so_a[d]);
          pos[d]++;
          if (m_last) begin
            check("word", d, cap[d] & m_mask, wbuf[d][0] & m_mask);
            wbuf[d][0] = wbuf[d][1];
            cnt[d]--;
            pos[d] = 0;
            cap[d] = '0;
          end
        end
        if (rst) begin
          cnt[d] = 0; pos[d] = 0; cap[d] = '0;
        end else if (dv[d] && m_ready) begin
          wbuf[d][cnt[d]] = din_a[d];
          cnt[d]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  s1_bits;
  logic [3:0]  s2_bits;
  logic [15:0] s3_bits;
  logic [7:0]  s4_bits;
  logic [7:0]  s5_bits;

  initial begin
    total = 0; bad = 0; chk_on = 1'b0;
    rst = 1'b1;
    if0.din = '0; if0.din_valid = 1'b0;
    if1.din = '0; if1.din_valid = 1'b0;
    if2.din = '0; if2.din_valid = 1'b0;
    tick();
    tick();
    chk_on = 1'b1;
    @(negedge clk);
    check("rst_ready", 2, 32'(if2.din_ready), 32'd1);
    check("rst_valid", 2, 32'(if2.so_valid), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // 4'b1011 on MSB-first and LSB-first 4-bit instances.
    s1_bits = 4'b1101;  // so sequence 1,0,1,1 listed LSB-index first
    s2_bits = 4'b1011;  // so sequence 1,1,0,1 listed LSB-index first
    if0.din = 4'b1011; if0.din_valid = 1'b1;
    if1.din = 4'b1011; if1.din_valid = 1'b1;
    tick();
    if0.din_valid = 1'b0; if1.din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("s1_so",   0, 32'(if0.so), 32'(s1_bits[i]));
      check("s1_last", 0, 32'(if0.so_last), 32'(i == 3));
      check("s2_so",   1, 32'(if1.so), 32'(s2_bits[i]));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("s1_idle_ready", 0, 32'(if0.din_ready), 32'd1);
    check("s1_idle_valid", 0, 32'(if0.so_valid), 32'd0);
    @(posedge clk); #1;

    // A5 then 3C back-to-back with din_valid held high.
    s3_bits = 16'hA53C;
    if2.din = 8'hA5; if2.din_valid = 1'b1;
    tick();
    if2.din = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("s3_so",    2, 32'(if2.so), 32'(s3_bits[15-i]));
      check("s3_last",  2, 32'(if2.so_last), 32'((i == 7) || (i == 15)));
      check("s3_valid", 2, 32'(if2.so_valid), 32'd1);
      @(posedge clk); #1;
      if (i == 7) if2.din_valid = 1'b0;
    end
    @(negedge clk);
    check("s3_idle_valid", 2, 32'(if2.so_valid), 32'd0);
    @(posedge clk); #1;

    // Toggled din_valid with new data while busy must be ignored.
    s4_bits = 8'hC3;
    if2.din = 8'hC3; if2.din_valid = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("s4_so", 2, 32'(if2.so), 32'(s4_bits[7-i]));
      @(posedge clk); #1;
      if (i < 6) begin
        if2.din_valid = ~if2.din_valid;
        if2.din = (i % 2 == 0) ? 8'h00 : 8'hFF;
      end else begin
        if2.din_valid = 1'b0;
      end
    end
    tick();

    // Reset after 3 bits of FF, with a word offered during the reset cycle.
    if2.din = 8'hFF; if2.din_valid = 1'b1;
    tick();
    if2.din_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1; if2.din = 8'h55; if2.din_valid = 1'b1;
    tick();
    rst = 1'b0; if2.din_valid = 1'b0;
    @(negedge clk);
    check("s5_valid", 2, 32'(if2.so_valid), 32'd0);
    check("s5_busy",  2, 32'(if2.busy), 32'd0);
    check("s5_ready", 2, 32'(if2.din_ready), 32'd1);
    check("s5_last",  2, 32'(if2.so_last), 32'd0);
    @(posedge clk); #1;
    s5_bits = 8'h81;
    if2.din = 8'h81; if2.din_valid = 1'b1;
    tick();
    if2.din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("s5_so", 2, 32'(if2.so), 32'(s5_bits[7-i]));
      @(posedge clk); #1;
    end

    // Random words with random valid gaps on all instances.
    for (int n = 0; n < 2600; n++) begin
      if0.din = 4'($urandom); if0.din_valid = ($urandom_range(0, 3) != 0);
      if1.din = 4'($urandom); if1.din_valid = ($urandom_range(0, 3) != 0);
      if2.din = 8'($urandom); if2.din_valid = ($urandom_range(0, 3) != 0);
      tick();
    end
    if0.din_valid = 1'b0; if1.din_valid = 1'b0; if2.din_valid = 1'b0;
    repeat (20) tick();

    if (bad == 0) $display("PASSED");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
